// File: rtl/pong_if.sv
// Signal bundle between the paddle/serve controls and pong_arena, and
// from pong_arena to the VGA renderer and score display.
interface pong_if #(
  parameter int SCORE_W = 4
);
  logic               frame_tick;
  logic               enable;
  logic               serve;
  logic [8:0]         p1_y;
  logic [8:0]         p2_y;
  logic [9:0]         ball_x;
  logic [8:0]         ball_y;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic               point_p1;
  logic               point_p2;
  logic               game_over;
  logic               winner;
  logic [1:0]         state;

  modport master (
    output frame_tick, enable, serve, p1_y, p2_y,
    input  ball_x, ball_y, score1, score2, point_p1, point_p2,
           game_over, winner, state
  );

  modport slave (
    input  frame_tick, enable, serve, p1_y, p2_y,
    output ball_x, ball_y, score1, score2, point_p1, point_p2,
           game_over, winner, state
  );
endinterface

// File: rtl/pong_arena.sv
// Pong ball/paddle/score engine: one physics step per enabled frame_tick.
// Optional macro PONG_SPEEDUP_EN: every paddle hit raises the ball step by 1 up to MAX_STEP.
//
// state | meaning
// IDLE  | power-up, ball centred, waiting for serve
// SERVE | ball centred, counting SERVE_FRAMES frames before launch
// PLAY  | ball moving, collisions and scoring evaluated per frame
// OVER  | a player reached WIN_SCORE; serve starts a new game
module pong_arena #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int PADDLE_H     = 75,
  parameter int PADDLE_W     = 5,
  parameter int P1_X         = 30,
  parameter int P2_X         = 600,
  parameter int BALL_R       = 5,
  parameter int STEP         = 2,
  parameter int MAX_STEP     = 6,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9,
  parameter int SCORE_W      = 4
) (
  input  logic  clk_out,
  input  logic  reset,
  pong_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_PLAY  = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam int STEP_W = $clog2(MAX_STEP + 1);
  localparam int CNT_W  = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

  localparam logic [9:0]         X_MID     = 10'(H_RES / 2);
  localparam logic [8:0]         Y_MID     = 9'(V_RES / 2);
  localparam logic [STEP_W-1:0]  STEP_INIT = STEP_W'(STEP);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_SCORE);

  // Geometry in 11-bit signed so that x-step and y-BALL_R can go negative without wrapping.
  localparam logic signed [10:0] BR       = 11'(BALL_R);
  localparam logic signed [10:0] P1_LEFT  = 11'(P1_X);
  localparam logic signed [10:0] P1_RIGHT = 11'(P1_X + PADDLE_W - 1);
  localparam logic signed [10:0] P2_LEFT  = 11'(P2_X);
  localparam logic signed [10:0] P2_RIGHT = 11'(P2_X + PADDLE_W - 1);
  localparam logic signed [10:0] PAD_SPAN = 11'(PADDLE_H - 1);
  localparam logic signed [10:0] X_HIT_L  = 11'(P1_X + PADDLE_W + BALL_R);
  localparam logic signed [10:0] X_HIT_R  = 11'(P2_X - 1 - BALL_R);
  localparam logic signed [10:0] X_MISS_R = 11'(H_RES - 1 - BALL_R);
  localparam logic signed [10:0] Y_TOP    = 11'(BALL_R);
  localparam logic signed [10:0] Y_BOT    = 11'(V_RES - 1 - BALL_R);
  localparam logic signed [10:0] Y_EDGE   = 11'(V_RES - 1);

  state_t             state_q, state_nxt;
  logic [9:0]         x_q, x_nxt;
  logic [8:0]         y_q, y_nxt;
  logic               dx_q, dx_nxt;
  logic               dy_q, dy_nxt;
  logic [STEP_W-1:0]  step_q, step_nxt, step_hit;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [SCORE_W-1:0] score1_q, score1_nxt, score1_inc;
  logic [SCORE_W-1:0] score2_q, score2_nxt, score2_inc;
  logic               pt1_q, pt1_nxt, pt2_q, pt2_nxt;
  logic               over_q, over_nxt, winner_q, winner_nxt;

  logic               tick;
  logic signed [10:0] xs, ys, stp, nxs, nys, p1s, p2s;
  logic               hit_l, hit_r, miss_l, miss_r, wall_top, wall_bot;
  logic               unused_bits;

  assign tick = bus.frame_tick & bus.enable;
  assign xs   = signed'({1'b0, x_q});
  assign ys   = signed'({2'b00, y_q});
  assign stp  = signed'(11'(step_q));
  assign p1s  = signed'({2'b00, bus.p1_y});
  assign p2s  = signed'({2'b00, bus.p2_y});
  assign nxs  = dx_q ? xs + stp : xs - stp;
  assign nys  = dy_q ? ys + stp : ys - stp;

  assign wall_top = !dy_q && (nys - BR <= 11'sd0);
  assign wall_bot =  dy_q && (nys + BR >= Y_EDGE);

  // Paddle tests use the pre-update y and take priority over a miss in the same frame.
  assign hit_l = !dx_q && (nxs - BR <= P1_RIGHT) && (xs - BR >= P1_LEFT) &&
                 (ys + BR >= p1s) && (ys - BR <= p1s + PAD_SPAN);
  assign hit_r =  dx_q && (nxs + BR >= P2_LEFT) && (xs + BR <= P2_RIGHT) &&
                 (ys + BR >= p2s) && (ys - BR <= p2s + PAD_SPAN);
  assign miss_l = !dx_q && !hit_l && (nxs <= BR);
  assign miss_r =  dx_q && !hit_r && (nxs >= X_MISS_R);

  assign score1_inc  = score1_q + 1'b1;
  assign score2_inc  = score2_q + 1'b1;
  assign unused_bits = ^{nxs[10], nys[10:9]};

`ifdef PONG_SPEEDUP_EN
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(MAX_STEP);
  assign step_hit = (step_q >= STEP_MAX) ? STEP_MAX : step_q + 1'b1;
`else
  assign step_hit = step_q;
`endif

  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      x_q      <= X_MID;
      y_q      <= Y_MID;
      dx_q     <= 1'b1;
      dy_q     <= 1'b1;
      step_q   <= STEP_INIT;
      cnt_q    <= '0;
      score1_q <= '0;
      score2_q <= '0;
      pt1_q    <= 1'b0;
      pt2_q    <= 1'b0;
      over_q   <= 1'b0;
      winner_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      x_q      <= x_nxt;
      y_q      <= y_nxt;
      dx_q     <= dx_nxt;
      dy_q     <= dy_nxt;
      step_q   <= step_nxt;
      cnt_q    <= cnt_nxt;
      score1_q <= score1_nxt;
      score2_q <= score2_nxt;
      pt1_q    <= pt1_nxt;
      pt2_q    <= pt2_nxt;
      over_q   <= over_nxt;
      winner_q <= winner_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    x_nxt      = x_q;
    y_nxt      = y_q;
    dx_nxt     = dx_q;
    dy_nxt     = dy_q;
    step_nxt   = step_q;
    cnt_nxt    = cnt_q;
    score1_nxt = score1_q;
    score2_nxt = score2_q;
    pt1_nxt    = 1'b0;
    pt2_nxt    = 1'b0;
    winner_nxt = winner_q;

    case (state_q)
      S_IDLE: begin
        x_nxt = X_MID;
        y_nxt = Y_MID;
        if (bus.serve) begin
          state_nxt = S_SERVE;
          cnt_nxt   = '0;
        end
      end

      S_SERVE: begin
        x_nxt = X_MID;
        y_nxt = Y_MID;
        if (tick) begin
          if (cnt_q == CNT_LAST) begin
            state_nxt = S_PLAY;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
      end

      S_PLAY: begin
        if (tick) begin
          if (miss_l || miss_r) begin
            // Relaunch toward the player who just conceded.
            x_nxt    = X_MID;
            y_nxt    = Y_MID;
            dx_nxt   = miss_r;
            dy_nxt   = 1'b1;
            step_nxt = STEP_INIT;
            cnt_nxt  = '0;
            if (miss_r) begin
              score1_nxt = score1_inc;
              pt1_nxt    = 1'b1;
              if (score1_inc == SCORE_WIN) begin
                state_nxt  = S_OVER;
                winner_nxt = 1'b0;
              end else begin
                state_nxt = S_SERVE;
              end
            end else begin
              score2_nxt = score2_inc;
              pt2_nxt    = 1'b1;
              if (score2_inc == SCORE_WIN) begin
                state_nxt  = S_OVER;
                winner_nxt = 1'b1;
              end else begin
                state_nxt = S_SERVE;
              end
            end
          end else begin
            if (wall_top) begin
              y_nxt  = Y_TOP[8:0];
              dy_nxt = 1'b1;
            end else if (wall_bot) begin
              y_nxt  = Y_BOT[8:0];
              dy_nxt = 1'b0;
            end else begin
              y_nxt = nys[8:0];
            end

            if (hit_l) begin
              x_nxt    = X_HIT_L[9:0];
              dx_nxt   = 1'b1;
              step_nxt = step_hit;
            end else if (hit_r) begin
              x_nxt    = X_HIT_R[9:0];
              dx_nxt   = 1'b0;
              step_nxt = step_hit;
            end else begin
              x_nxt = nxs[9:0];
            end
          end
        end
      end

      S_OVER: begin
        x_nxt = X_MID;
        y_nxt = Y_MID;
        if (bus.serve) begin
          score1_nxt = '0;
          score2_nxt = '0;
          winner_nxt = 1'b0;
          step_nxt   = STEP_INIT;
          cnt_nxt    = '0;
          state_nxt  = S_SERVE;
        end
      end

      default: state_nxt = S_IDLE;
    endcase

    over_nxt = (state_nxt == S_OVER);
  end

  assign bus.ball_x    = x_q;
  assign bus.ball_y    = y_q;
  assign bus.score1    = score1_q;
  assign bus.score2    = score2_q;
  assign bus.point_p1  = pt1_q;
  assign bus.point_p2  = pt2_q;
  assign bus.game_over = over_q;
  assign bus.winner    = winner_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_pong_arena.sv
// Bench for pong_arena: a reference game model pushes expected outputs per frame into a
// queue that a monitor pops and compares one cycle later; scenario tasks add spot checks.
module tb_pong_arena;
  localparam int H_RES = 640, V_RES = 480, PADDLE_H = 75, PADDLE_W = 5;
  localparam int P1_X = 30, P2_X = 600, BALL_R = 5, STEP = 2, MAX_STEP = 6;
  localparam int SERVE_FRAMES = 60, WIN_SCORE = 9;
`ifdef PONG_SPEEDUP_EN
  localparam int STEP_AFTER_HIT = 3;
`else
  localparam int STEP_AFTER_HIT = 2;
`endif

  logic clk_out = 1'b0;
  logic reset;

  pong_if #(.SCORE_W(4)) bus ();

  pong_arena dut (
    .clk_out (clk_out),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_out = ~clk_out;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] st;
    logic       p1;
    logic       p2;
    logic       over;
    logic       win;
  } obs_t;

  typedef struct {
    obs_t v;
    int   due;
  } sb_t;

  sb_t sb_q[$];
  int  cyc = 0;
  int  n_vec = 0;
  int  n_err = 0;

  // Reference model state
  int m_x, m_y, m_dx, m_dy, m_step, m_cnt, m_s1, m_s2, m_st, m_win;
  bit m_p1, m_p2;
  int p1v, p2v;
  int p2_avoid;
  int hits_l, hits_r, b_top, b_bot;

  task automatic model_init();
    m_x = H_RES / 2; m_y = V_RES / 2; m_dx = 1; m_dy = 1; m_step = STEP;
    m_cnt = 0; m_s1 = 0; m_s2 = 0; m_st = 0; m_win = 0; m_p1 = 0; m_p2 = 0;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.x = 10'(m_x); o.y = 9'(m_y); o.s1 = 4'(m_s1); o.s2 = 4'(m_s2);
    o.st = 2'(m_st); o.p1 = m_p1; o.p2 = m_p2; o.over = (m_st == 3); o.win = 1'(m_win);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.x = bus.ball_x; o.y = bus.ball_y; o.s1 = bus.score1; o.s2 = bus.score2;
    o.st = bus.state; o.p1 = bus.point_p1; o.p2 = bus.point_p2;
    o.over = bus.game_over; o.win = bus.winner;
    return o;
  endfunction

  task automatic model_tick(input bit en);
    int nx, ny, ny2, ndy, scorer;
    m_p1 = 0; m_p2 = 0;
    if (!en) return;
    if (m_st == 1) begin
      if (m_cnt == SERVE_FRAMES - 1) begin m_st = 2; m_cnt = 0; end
      else m_cnt++;
    end else if (m_st == 2) begin
      nx = (m_dx != 0) ? m_x + m_step : m_x - m_step;
      ny = (m_dy != 0) ? m_y + m_step : m_y - m_step;
      ndy = m_dy;
      ny2 = ny;
      if (m_dy == 0 && ny - BALL_R <= 0) begin ny2 = BALL_R; ndy = 1; b_top++; end
      else if (m_dy != 0 && ny + BALL_R >= V_RES - 1) begin ny2 = V_RES - 1 - BALL_R; ndy = 0; b_bot++; end
      scorer = 0;
      if (m_dx == 0) begin
        if (nx - BALL_R <= P1_X + PADDLE_W - 1 && m_x - BALL_R >= P1_X &&
            m_y + BALL_R >= p1v && m_y - BALL_R <= p1v + PADDLE_H - 1) begin
          nx = P1_X + PADDLE_W + BALL_R; m_dx = 1; hits_l++;
`ifdef PONG_SPEEDUP_EN
          if (m_step < MAX_STEP) m_step++;
`endif
        end else if (nx <= BALL_R) scorer = 2;
      end else begin
        if (nx + BALL_R >= P2_X && m_x + BALL_R <= P2_X + PADDLE_W - 1 &&
            m_y + BALL_R >= p2v && m_y - BALL_R <= p2v + PADDLE_H - 1) begin
          nx = P2_X - 1 - BALL_R; m_dx = 0; hits_r++;
`ifdef PONG_SPEEDUP_EN
          if (m_step < MAX_STEP) m_step++;
`endif
        end else if (nx >= H_RES - 1 - BALL_R) scorer = 1;
      end
      if (scorer == 0) begin
        m_x = nx; m_y = ny2; m_dy = ndy;
      end else begin
        m_x = H_RES / 2; m_y = V_RES / 2; m_dy = 1; m_step = STEP; m_cnt = 0;
        m_dx = (scorer == 1) ? 1 : 0;
        if (scorer == 1) begin m_s1++; m_p1 = 1; end
        else begin m_s2++; m_p2 = 1; end
        if (m_s1 == WIN_SCORE || m_s2 == WIN_SCORE) begin m_st = 3; m_win = (scorer == 2) ? 1 : 0; end
        else m_st = 1;
      end
    end
  endtask

  task automatic push_expect();
    sb_t e;
    e.v = model_obs(); e.due = cyc + 1; sb_q.push_back(e);
    m_p1 = 0; m_p2 = 0;
    e.v = model_obs(); e.due = cyc + 2; sb_q.push_back(e);
  endtask

  task automatic tick(input bit en);
    p1v = (m_y - 37 < 0) ? 0 : m_y - 37;
    if (p2_avoid != 0) p2v = (m_y >= 240) ? 0 : 400;
    else p2v = (m_y - 37 < 0) ? 0 : m_y - 37;
    bus.p1_y = 9'(p1v);
    bus.p2_y = 9'(p2v);
    bus.frame_tick = 1'b1;
    bus.enable = en;
    model_tick(en);
    push_expect();
    @(posedge clk_out); #1;
    bus.frame_tick = 1'b0;
    bus.enable = 1'b1;
    @(posedge clk_out); #1;
    @(posedge clk_out); #1;
  endtask

  task automatic do_serve();
    bus.serve = 1'b1;
    if (m_st == 0) begin m_st = 1; m_cnt = 0; end
    else if (m_st == 3) begin
      m_s1 = 0; m_s2 = 0; m_win = 0; m_step = STEP; m_st = 1; m_cnt = 0;
    end
    push_expect();
    @(posedge clk_out); #1;
    bus.serve = 1'b0;
    @(posedge clk_out); #1;
    @(posedge clk_out); #1;
  endtask

  // Scoreboard monitor: compares every expected entry in the cycle it falls due.
  initial begin
    sb_t e;
    obs_t o;
    forever begin
      @(posedge clk_out);
      cyc++;
      #2;
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        o = dut_obs();
        n_vec++;
        if (o !== e.v) begin
          n_err++;
          $display("FAIL sb cyc%0d got x=%0d y=%0d s=%0d/%0d st=%0d pt=%b%b ov=%b w=%b need x=%0d y=%0d s=%0d/%0d st=%0d pt=%b%b ov=%b w=%b",
                   cyc, o.x, o.y, o.s1, o.s2, o.st, o.p1, o.p2, o.over, o.win,
                   e.v.x, e.v.y, e.v.s1, e.v.s2, e.v.st, e.v.p1, e.v.p2, e.v.over, e.v.win);
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    obs_t o, e;
    o = dut_obs();
    e = '0;
    e.x = 10'd320; e.y = 9'd240;
    n_vec++;
    if (o !== e) begin
      n_err++;
      $display("FAIL %s got x=%0d y=%0d s=%0d/%0d st=%0d pt=%b%b ov=%b w=%b need x=320 y=240 all else 0",
               tag, o.x, o.y, o.s1, o.s2, o.st, o.p1, o.p2, o.over, o.win);
    end
  endtask

  task automatic test_reset();
    #23;
    check_reset_values("reset_state");
    @(posedge clk_out); #1;
    reset = 1'b0;
    model_init();
    tick(1);
    do_serve();
    do_serve();
  endtask

  task automatic test_serve();
    for (int i = 0; i < SERVE_FRAMES - 1; i++) tick(1);
    n_vec++;
    if (bus.state !== 2'd1) begin n_err++; $display("FAIL serve_hold state=%0d need 1", bus.state); end
    tick(1);
    n_vec++;
    if (bus.state !== 2'd2) begin n_err++; $display("FAIL serve_to_play state=%0d need 2", bus.state); end
    tick(1);
    n_vec++;
    if (bus.ball_x !== 10'd322 || bus.ball_y !== 9'd242) begin
      n_err++; $display("FAIL first_move got (%0d,%0d) need (322,242)", bus.ball_x, bus.ball_y);
    end
    tick(1);
    n_vec++;
    if (bus.ball_x !== 10'd324) begin n_err++; $display("FAIL second_move x=%0d need 324", bus.ball_x); end
  endtask

  task automatic test_paddle_hit();
    bit done;
    p2_avoid = 0;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      int hr, hl, bt;
      hr = hits_r; hl = hits_l; bt = b_top;
      tick(1);
      if (hits_r == 1 && hr == 0) begin
        n_vec++;
        if (bus.ball_x !== 10'd594 || bus.point_p1 !== 1'b0) begin
          n_err++; $display("FAIL p2_hit_clamp x=%0d pt1=%b need 594 0", bus.ball_x, bus.point_p1);
        end
        tick(1);
        n_vec++;
        if (bus.ball_x !== 10'(594 - STEP_AFTER_HIT)) begin
          n_err++; $display("FAIL p2_hit_rebound x=%0d need %0d", bus.ball_x, 594 - STEP_AFTER_HIT);
        end
      end
      if (hits_l == 1 && hl == 0) begin
        n_vec++;
        if (bus.ball_x !== 10'd40) begin n_err++; $display("FAIL p1_hit_clamp x=%0d need 40", bus.ball_x); end
      end
      if (b_top == 1 && bt == 0) begin
        n_vec++;
        if (bus.ball_y !== 9'd5) begin n_err++; $display("FAIL top_wall y=%0d need 5", bus.ball_y); end
      end
      done = (hits_l >= 1 && hits_r >= 2 && b_top >= 1 && b_bot >= 1);
    end
    n_vec++;
    if (!done) begin
      n_err++; $display("FAIL rally_timeout hits=%0d/%0d walls=%0d/%0d", hits_l, hits_r, b_top, b_bot);
    end
  endtask

  task automatic test_score();
    int s1_before;
    s1_before = m_s1;
    p2_avoid = 1;
    for (int i = 0; i < 1000 && m_s1 == s1_before; i++) tick(1);
    n_vec++;
    if (bus.score1 !== 4'(s1_before + 1) || bus.state !== 2'd1 ||
        bus.ball_x !== 10'd320 || bus.ball_y !== 9'd240) begin
      n_err++;
      $display("FAIL p1_point got s1=%0d st=%0d (%0d,%0d) need s1=%0d st=1 (320,240)",
               bus.score1, bus.state, bus.ball_x, bus.ball_y, s1_before + 1);
    end
    for (int i = 0; i < SERVE_FRAMES + 1; i++) tick(1);
    n_vec++;
    if (bus.ball_x !== 10'd322) begin n_err++; $display("FAIL relaunch_dir x=%0d need 322", bus.ball_x); end
  endtask

  task automatic test_win();
    p2_avoid = 1;
    for (int i = 0; i < 4000 && m_st != 3; i++) tick(1);
    n_vec++;
    if (bus.game_over !== 1'b1 || bus.winner !== 1'b0 || bus.score1 !== 4'd9 || bus.state !== 2'd3) begin
      n_err++;
      $display("FAIL win got over=%b w=%b s1=%0d st=%0d need 1 0 9 3",
               bus.game_over, bus.winner, bus.score1, bus.state);
    end
    tick(1);
    do_serve();
    n_vec++;
    if (bus.score1 !== 4'd0 || bus.score2 !== 4'd0 || bus.state !== 2'd1 || bus.game_over !== 1'b0) begin
      n_err++;
      $display("FAIL new_game got s=%0d/%0d st=%0d over=%b need 0/0 1 0",
               bus.score1, bus.score2, bus.state, bus.game_over);
    end
  endtask

  task automatic test_enable_and_reset();
    logic [9:0] hx;
    logic [8:0] hy;
    p2_avoid = 0;
    for (int i = 0; i < SERVE_FRAMES + 3; i++) tick(1);
    hx = bus.ball_x;
    hy = bus.ball_y;
    for (int i = 0; i < 10; i++) tick(0);
    n_vec++;
    if (bus.ball_x !== hx || bus.ball_y !== hy || bus.state !== 2'd2) begin
      n_err++;
      $display("FAIL enable_hold got (%0d,%0d) st=%0d need (%0d,%0d) st=2",
               bus.ball_x, bus.ball_y, bus.state, hx, hy);
    end
    tick(1);
    #3;
    reset = 1'b1;
    #1;
    check_reset_values("reset_mid_play");
    sb_q.delete();
    model_init();
    @(posedge clk_out); #1;
    reset = 1'b0;
    tick(1);
    do_serve();
    tick(1);
  endtask

  initial begin
    reset = 1'b1;
    bus.frame_tick = 1'b0;
    bus.enable = 1'b1;
    bus.serve = 1'b0;
    bus.p1_y = 9'd0;
    bus.p2_y = 9'd0;
    p1v = 0; p2v = 0; p2_avoid = 0;
    hits_l = 0; hits_r = 0; b_top = 0; b_bot = 0;
    model_init();
    test_reset();
    test_serve();
    test_paddle_hit();
    test_score();
    test_win();
    test_enable_and_reset();
    repeat (4) @(posedge clk_out);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
